// File: rtl/muldiv4_bist.sv
// Built-in self-test master for the 4-bit multiply/divide core. It sweeps every operand
// pair, computes the golden result with its own bit-serial engine and tallies mismatches.
module muldiv4_bist #(
  parameter int WIDTH       = 4,
  parameter int DUT_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  output logic               dut_op,
  input  logic [2*WIDTH-1:0] dut_res,
  input  logic               dut_dbz,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic               fail_op
);

  localparam int VW        = 2 * WIDTH;
  localparam int APPLY_LEN = (DUT_LATENCY > WIDTH) ? DUT_LATENCY : WIDTH;
  localparam int SW        = $clog2(APPLY_LEN + 1);
  localparam int IW        = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, APPLY, CHECK, NEXT, DONE} state_t;

  state_t           state;
  logic [SW-1:0]    step;
  logic             both_ops;
  logic [VW-1:0]    prod_g;
  logic [WIDTH-1:0] rem_g;
  logic [WIDTH-1:0] quo_g;

  logic [IW-1:0]    b_idx;
  logic [IW-1:0]    a_idx;
  logic [VW-1:0]    prod_next;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH:0]   div_next;
  logic [WIDTH-1:0] quo_next;
  logic [VW-1:0]    vec;
  logic [VW-1:0]    golden;
  logic             mismatch;

  // One shift-add and one restoring-divide step per APPLY cycle; partials restart at step 0.
  always_comb begin
    b_idx     = step[IW-1:0];
    a_idx     = IW'(WIDTH - 1) - step[IW-1:0];
    prod_next = (step == '0) ? '0 : prod_g;
    if (dut_b[b_idx])
      prod_next = prod_next + ({{WIDTH{1'b0}}, dut_a} << step);
    div_trial = (step == '0) ? {{WIDTH{1'b0}}, dut_a[a_idx]} : {rem_g, dut_a[a_idx]};
    div_ge    = div_trial >= {1'b0, dut_b};
    div_next  = div_ge ? (div_trial - {1'b0, dut_b}) : div_trial;
    quo_next  = (step == '0) ? {{(WIDTH-1){1'b0}}, div_ge} : {quo_g[WIDTH-2:0], div_ge};
    vec       = {dut_a, dut_b};
    golden    = dut_op ? prod_g : {rem_g, quo_g};
    mismatch  = (dut_res != golden) || (!dut_op && (dut_dbz != (dut_b == '0)));
  end

  // A zero divisor never fails the trial subtract, so it yields quotient all-ones and remainder a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step       <= '0;
      both_ops   <= 1'b0;
      prod_g     <= '0;
      rem_g      <= '0;
      quo_g      <= '0;
      dut_a      <= '0;
      dut_b      <= '0;
      dut_op     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_op    <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= APPLY;
            step       <= '0;
            both_ops   <= mode[1];
            dut_a      <= '0;
            dut_b      <= '0;
            dut_op     <= (mode != 2'b01);
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_op    <= 1'b0;
          end
        end
        APPLY: begin
          if (step < SW'(WIDTH)) begin
            prod_g <= prod_next;
            rem_g  <= div_next[WIDTH-1:0];
            quo_g  <= quo_next;
          end
          step <= step + SW'(1);
          if (step == SW'(APPLY_LEN - 1))
            state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != 8'hFF)
              err_count <= err_count + 8'd1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= dut_a;
              fail_b     <= dut_b;
              fail_op    <= dut_op;
            end
          end
          state <= NEXT;
        end
        NEXT: begin
          {dut_a, dut_b} <= vec + VW'(1);
          step           <= '0;
          if (vec == {VW{1'b1}}) begin
            if (dut_op && both_ops) begin
              dut_op <= 1'b0;
              state  <= APPLY;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == 8'd0);
            end
          end else begin
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv4_bist.sv
// Directed bench for muldiv4_bist: a behavioural muldiv model with selectable faults
// answers the BIST, and each run's totals, timing and first-failure capture are checked.
module tb_muldiv4_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] dut_a, dut_b, fail_a, fail_b;
  logic       dut_op, busy, done, pass, fail_valid, fail_op;
  logic [7:0] err_count;
  logic [7:0] res_m = 8'd0;
  logic       dbz_m = 1'b0;

  int fault = 0;
  int passed = 0;
  int total = 0;
  int cyc;

  always #5 clk = ~clk;

  muldiv4_bist #(.WIDTH(4), .DUT_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode),
    .dut_a(dut_a), .dut_b(dut_b), .dut_op(dut_op),
    .dut_res(res_m), .dut_dbz(dbz_m),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b), .fail_op(fail_op)
  );

  // Behavioural muldiv core, one cycle latency; fault 1 flips a bit of 3*5,
  // fault 2 drops the divide-by-zero flag, fault 3 sticks the result at zero.
  always @(posedge clk) begin
    if (fault == 3) begin
      res_m <= 8'd0;
      dbz_m <= 1'b0;
    end else if (dut_op) begin
      res_m <= (8'(dut_a) * 8'(dut_b)) ^ ((fault == 1 && dut_a == 4'd3 && dut_b == 4'd5) ? 8'h01 : 8'h00);
      dbz_m <= 1'b0;
    end else if (dut_b == 4'd0) begin
      res_m <= {dut_a, 4'hF};
      dbz_m <= (fault != 2);
    end else begin
      res_m <= {dut_a % dut_b, dut_a / dut_b};
      dbz_m <= 1'b0;
    end
  end

  function automatic logic [29:0] outs();
    return {busy, done, pass, err_count, fail_valid, fail_a, fail_b, fail_op, dut_a, dut_b, dut_op};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    else
      passed++;
  endtask

  // Starts one run and counts cycles from busy rising to done; can also poke start
  // while busy, freeze with ena, or pulse reset at a given cycle (run then aborts).
  task automatic applyStimulus(input logic [1:0] m, input int flt, input int freeze_at,
                               input int freeze_len, input int poke_at, input int reset_at,
                               output int cycles);
    logic [29:0] snap;
    logic        same;
    logic        aborted;
    fault = flt;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_rise", busy, 1);
    checkOutput("start_clear", {done, pass, fail_valid, err_count, dut_a, dut_b}, 0);
    checkOutput("start_op", dut_op, (m != 2'b01));
    cycles  = 0;
    aborted = 1'b0;
    while (!done && !aborted && cycles < 10000) begin
      if (cycles == freeze_at) begin
        snap = outs();
        same = 1'b1;
        ena  = 1'b0;
        repeat (freeze_len) begin
          @(negedge clk);
          cycles++;
          if (outs() !== snap) same = 1'b0;
        end
        ena = 1'b1;
        checkOutput("freeze_hold", same, 1);
      end
      if (cycles == poke_at) begin
        start = 1'b1;
        mode  = 2'b01;
      end else begin
        start = 1'b0;
        mode  = m;
      end
      if (cycles == reset_at) begin
        checkOutput("pre_reset_a", dut_a, (reset_at / 6) >> 4);
        checkOutput("pre_reset_b", dut_b, (reset_at / 6) & 15);
        checkOutput("pre_reset_err", err_count, (flt == 1) ? 1 : 0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", outs(), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        aborted = 1'b1;
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
    start = 1'b0;
    if (!aborted && !done)
      checkOutput("timeout", 0, 1);
  endtask

  initial begin
    #12;
    checkOutput("reset_outs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(2'b00, 0, -1, 0, 100, -1, cyc);
    checkOutput("t1_cycles", cyc, 1536);
    checkOutput("t1_pass", pass, 1);
    checkOutput("t1_err", err_count, 0);
    checkOutput("t1_busy_low", busy, 0);
    checkOutput("t1_fail_valid", fail_valid, 0);

    @(negedge clk);
    ena   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ena   = 1'b1;
    @(negedge clk);
    checkOutput("start_no_ena", {busy, done}, 2'b01);

    applyStimulus(2'b10, 1, -1, 0, -1, -1, cyc);
    checkOutput("t2_cycles", cyc, 3072);
    checkOutput("t2_err", err_count, 1);
    checkOutput("t2_fail", {fail_valid, fail_a, fail_b, fail_op}, {1'b1, 4'd3, 4'd5, 1'b1});
    checkOutput("t2_pass", pass, 0);

    applyStimulus(2'b01, 2, -1, 0, -1, -1, cyc);
    checkOutput("t3_cycles", cyc, 1536);
    checkOutput("t3_err", err_count, 16);
    checkOutput("t3_fail", {fail_valid, fail_a, fail_b, fail_op}, {1'b1, 4'd0, 4'd0, 1'b0});

    applyStimulus(2'b11, 3, -1, 0, -1, -1, cyc);
    checkOutput("t4_cycles", cyc, 3072);
    checkOutput("t4_done", {done, pass}, 2'b10);
    checkOutput("t4_err_sat", err_count, 255);
    checkOutput("t4_fail", {fail_valid, fail_a, fail_b, fail_op}, {1'b1, 4'd1, 4'd1, 1'b1});

    applyStimulus(2'b00, 1, -1, 0, -1, 602, cyc);
    applyStimulus(2'b00, 0, -1, 0, -1, -1, cyc);
    checkOutput("t5_cycles", cyc, 1536);
    checkOutput("t5_pass", {pass, err_count}, {1'b1, 8'd0});

    applyStimulus(2'b00, 0, 300, 50, -1, -1, cyc);
    checkOutput("t6_cycles", cyc, 1586);
    checkOutput("t6_pass", {pass, err_count}, {1'b1, 8'd0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
